dot_mac_stream: RTL and testbench
=================================

# dot_mac_stream

Parametrised, pipelined, streaming dot-product MAC for the matrix-multiply datapath. Each accepted beat carries LANES element pairs (row slice of A, column slice of B). The block multiplies per lane, reduces through a registered adder tree, and accumulates across beats until a beat flagged `in_last`. It then emits one saturated or wrapped r_ij result through a valid/ready output with backpressure.

## Interface
- DATA_W, 16, signed element width
- LANES, 10, element pairs per beat (>=1)
- ACC_W, 48, internal accumulator width; must be >= 2*DATA_W + clog2(LANES) + 8
- OUT_W, 32, result width (<= ACC_W)
- SAT_EN, 1, 1 = clamp result to signed OUT_W range; 0 = truncate (two's-complement wrap)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  beat present
- in_ready  out  1  block accepts beat this cycle
- in_last  in  1  beat is final of current dot product
- in_a  in  LANES*DATA_W  signed elements, lane k at bits [k*DATA_W +: DATA_W]
- in_b  in  LANES*DATA_W  signed elements, same packing
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- out_data  out  OUT_W  signed dot-product result
- out_sat  out  1  result was clamped (SAT_EN=1) or wrapped (SAT_EN=0) this result
- busy  out  1  any beat in pipeline or accumulator nonzero-in-progress

## Operation
- Global advance: adv = !out_valid || out_ready. in_ready = adv. Accept = in_valid && in_ready.
- When adv = 0, every pipeline register holds. No beat is dropped or duplicated.
- Stage 1 (on adv): lane products p_k = a_k*b_k, full 2*DATA_W signed. Also registers v1 = accept and l1 = in_last.
- Stage 2 (on adv): s = sign-extended sum of p_0..p_{LANES-1}, ACC_W wide. Also v2 <= v1, l2 <= l1.
- Stage 3 (on adv, if v2): t = acc + s.
  - If l2: out_data <= conv(t), out_sat <= flag, out_valid <= 1, acc <= 0.
  - Else: acc <= t.
- Stage 3 with adv and out_ready and no new l2 result: out_valid <= 0.
- conv(t):
  - SAT_EN=1: t > 2^(OUT_W-1)-1 gives max positive. t < -2^(OUT_W-1) gives min negative. Either case sets flag.
  - SAT_EN=0: low OUT_W bits. Flag set if t is not representable.
- Simultaneous out_ready and new result: the old result is consumed and the new result is loaded in the same edge. out_valid stays 1.
- in_valid=0 beats are bubbles (v=0). They do not touch acc.
- busy = v1 || v2 || acc_active. acc_active is set on a non-last stage-3 update and cleared on the last update.
- Reset: v1, v2, acc, acc_active, out_valid, out_sat, out_data cleared to 0. Reset mid-vector discards the partial sum and the held result. The first accept after reset starts a new vector.

## Timing
- Reset values: in_ready=1, out_valid=0, out_data=0, out_sat=0, busy=0.
- Latency: for a last beat accepted in cycle N with no stall, out_valid is high in cycle N+3.
- Throughput: one beat per cycle while out_ready=1 or out_valid=0.
- Back-to-back vectors need no gap. A single-beat vector every cycle yields one result per cycle.
- in_ready is combinational from out_valid/out_ready only. It never depends on in_valid.
- out_data/out_sat are stable while out_valid && !out_ready.

## Test plan
- Defaults. One beat, all a=2, b=3, in_last=1 -> out_data=60 in cycle N+3, out_sat=0.
- Three consecutive beats, a_k=1, b_k=k (k=0..9), last on the third -> single result 135. No out_valid before it.
- All lanes a=b=-32768, last=1:
  - SAT_EN=1 -> out_data=0x7FFFFFFF, out_sat=1.
  - SAT_EN=0 -> out_data=0x80000000, out_sat=1.
- Backpressure: stream four single-beat vectors with values 1..4 (a=k on lane 0 only, b=1), out_ready=0 for 6 cycles.
  - Results must hold at 1 and in_ready must be 0 while held.
  - On release, the bench must see 1,2,3,4 in order with no loss.
- Bubbles: beats separated by in_valid=0 cycles, a=b=1 all lanes, 2 beats -> 20. Random in_valid/out_ready over 1000 vectors -> results match a reference model.
- Reset: assert rst after the second of three beats, then send one beat a=b=1 with last -> out_data=10. Check all outputs are 0 in the cycle after rst.

Source files
------------

// File: rtl/dot_mac_if.sv
// dot_mac_if: streaming bus for dot_mac_stream.
//   Input side : in_valid/in_ready handshake, in_last, packed operand slices in_a/in_b.
//   Output side: out_valid/out_ready handshake, out_data result, out_sat overflow flag.
//   slave  modport: the MAC block.  master modport: producer/consumer.
interface dot_mac_if #(
   parameter int unsigned LANES  = 10,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned OUT_W  = 32
) ();
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_last;
   logic [LANES*DATA_W-1:0]   in_a;
   logic [LANES*DATA_W-1:0]   in_b;
   logic                      out_valid;
   logic                      out_ready;
   logic [OUT_W-1:0]          out_data;
   logic                      out_sat;

   modport slave (
      input  in_valid, in_last, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_sat
   );

   modport master (
      output in_valid, in_last, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_sat
   );
endinterface

// File: rtl/dot_mac_stream.sv
// dot_mac_stream: pipelined streaming dot-product MAC.
//   Stage 1 registers per-lane products, stage 2 registers their sign-extended
//   sum, stage 3 accumulates across beats and, on the last beat, converts the
//   total to OUT_W (saturate or wrap) into a held valid/ready result.
// Ports:
//   clk   - clock, all state on rising edge
//   rst   - synchronous active-high reset
//   bus   - dot_mac_if.slave (input beats, output result handshake)
//   busy  - a beat is in flight or a partial sum is being accumulated
module dot_mac_stream #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned LANES  = 10,
   parameter int unsigned ACC_W  = 48,
   parameter int unsigned OUT_W  = 32,
   parameter bit          SAT_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   dot_mac_if.slave    bus,
   output logic        busy
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   // Full-precision signed product of one lane.
   function automatic logic signed [PROD_W-1:0] lane_mul(
      input logic signed [DATA_W-1:0] a,
      input logic signed [DATA_W-1:0] b
   );
      logic signed [PROD_W-1:0] ae;
      logic signed [PROD_W-1:0] be;
      ae = PROD_W'(a);
      be = PROD_W'(b);
      return ae * be;
   endfunction

   logic                     adv_c;
   logic                     accept_c;

   logic signed [PROD_W-1:0] prod_q [LANES];
   logic signed [PROD_W-1:0] prod_d [LANES];
   logic                     v1_q, v1_d;
   logic                     l1_q, l1_d;

   logic signed [ACC_W-1:0]  sum_c;
   logic signed [ACC_W-1:0]  sum_q, sum_d;
   logic                     v2_q, v2_d;
   logic                     l2_q, l2_d;

   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic                     acc_active_q, acc_active_d;
   logic signed [ACC_W-1:0]  t_c;
   logic [ACC_W-OUT_W:0]     upper_c;
   logic                     over_c;
   logic [OUT_W-1:0]         conv_data_c;

   logic                     out_valid_q, out_valid_d;
   logic [OUT_W-1:0]         out_data_q, out_data_d;
   logic                     out_sat_q, out_sat_d;

   // Whole pipeline advances together; stalls only when a held result is not taken.
   assign adv_c        = !out_valid_q || bus.out_ready;
   assign accept_c     = bus.in_valid && adv_c;
   assign bus.in_ready = adv_c;

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sat   = out_sat_q;
   assign busy          = v1_q || v2_q || acc_active_q;

   // Lane products for the incoming beat.
   always_comb begin
      for (int k = 0; k < int'(LANES); k++) begin
         prod_d[k] = adv_c ? lane_mul(bus.in_a[k*DATA_W +: DATA_W], bus.in_b[k*DATA_W +: DATA_W])
                           : prod_q[k];
      end
   end

   // Reduction of stage-1 products.
   always_comb begin
      sum_c = '0;
      for (int k = 0; k < int'(LANES); k++) begin
         sum_c = sum_c + ACC_W'(prod_q[k]);
      end
   end

   // Running total and OUT_W conversion; overflow when the bits above the
   // OUT_W sign bit are not all copies of it.
   always_comb begin
      t_c     = acc_q + sum_q;
      upper_c = t_c[ACC_W-1:OUT_W-1];
      over_c  = !((&upper_c) || !(|upper_c));
      if (SAT_EN && over_c) begin
         conv_data_c = t_c[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
         conv_data_c = t_c[OUT_W-1:0];
      end
   end

   // Next-state for control, accumulator and result registers.
   always_comb begin
      v1_d         = v1_q;
      l1_d         = l1_q;
      sum_d        = sum_q;
      v2_d         = v2_q;
      l2_d         = l2_q;
      acc_d        = acc_q;
      acc_active_d = acc_active_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_sat_d    = out_sat_q;

      if (adv_c) begin
         v1_d  = accept_c;
         l1_d  = accept_c && bus.in_last;
         sum_d = sum_c;
         v2_d  = v1_q;
         l2_d  = l1_q;
         if (bus.out_ready) begin
            out_valid_d = 1'b0;
         end
         if (v2_q) begin
            if (l2_q) begin
               out_data_d   = conv_data_c;
               out_sat_d    = over_c;
               out_valid_d  = 1'b1;
               acc_d        = '0;
               acc_active_d = 1'b0;
            end else begin
               acc_d        = t_c;
               acc_active_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < int'(LANES); k++) begin
            prod_q[k] <= '0;
         end
         v1_q         <= 1'b0;
         l1_q         <= 1'b0;
         sum_q        <= '0;
         v2_q         <= 1'b0;
         l2_q         <= 1'b0;
         acc_q        <= '0;
         acc_active_q <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_sat_q    <= 1'b0;
      end else begin
         for (int k = 0; k < int'(LANES); k++) begin
            prod_q[k] <= prod_d[k];
         end
         v1_q         <= v1_d;
         l1_q         <= l1_d;
         sum_q        <= sum_d;
         v2_q         <= v2_d;
         l2_q         <= l2_d;
         acc_q        <= acc_d;
         acc_active_q <= acc_active_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_sat_q    <= out_sat_d;
      end
   end

endmodule

// File: tb/tb_dot_mac_stream.sv
// tb_dot_mac_stream: directed and randomised checks of dot_mac_stream.
//   Two instances share identical stimulus: dut_s saturates, dut_w wraps.
//   A negedge monitor keeps a reference accumulator and a queue of expected
//   results for every handshake on the output side.
module tb_dot_mac_stream;

   localparam int unsigned LANES  = 10;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned ACC_W  = 48;
   localparam int unsigned OUT_W  = 32;
   localparam int unsigned VW     = LANES * DATA_W;
   localparam longint      MAXP   = 64'sd2147483647;
   localparam longint      MINN   = -64'sd2147483648;

   typedef struct {
      logic [31:0] d_s;
      logic        f_s;
      logic [31:0] d_w;
      logic        f_w;
   } exp_t;

   logic clk;
   logic rst;
   logic busy_s, busy_w;

   int n_checks;
   int n_errors;

   exp_t        exp_q[$];
   logic [31:0] obs_q[$];
   longint      model_acc;
   bit          rand_done;

   dot_mac_if #(.LANES(LANES), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus_s ();
   dot_mac_if #(.LANES(LANES), .DATA_W(DATA_W), .OUT_W(OUT_W)) bus_w ();

   assign bus_w.in_valid  = bus_s.in_valid;
   assign bus_w.in_last   = bus_s.in_last;
   assign bus_w.in_a      = bus_s.in_a;
   assign bus_w.in_b      = bus_s.in_b;
   assign bus_w.out_ready = bus_s.out_ready;

   dot_mac_stream #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .SAT_EN(1'b1))
      dut_s (.clk(clk), .rst(rst), .bus(bus_s), .busy(busy_s));
   dot_mac_stream #(.DATA_W(DATA_W), .LANES(LANES), .ACC_W(ACC_W), .OUT_W(OUT_W), .SAT_EN(1'b0))
      dut_w (.clk(clk), .rst(rst), .bus(bus_w), .busy(busy_w));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic longint dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
      longint s;
      logic signed [DATA_W-1:0] x, y;
      s = 0;
      for (int k = 0; k < int'(LANES); k++) begin
         x = a[k*DATA_W +: DATA_W];
         y = b[k*DATA_W +: DATA_W];
         s = s + longint'(x) * longint'(y);
      end
      return s;
   endfunction

   function automatic exp_t conv(input longint t);
      exp_t e;
      logic over;
      over  = (t > MAXP) || (t < MINN);
      e.d_w = t[31:0];
      e.f_w = over;
      e.f_s = over;
      if (t > MAXP)      e.d_s = 32'h7FFF_FFFF;
      else if (t < MINN) e.d_s = 32'h8000_0000;
      else               e.d_s = t[31:0];
      return e;
   endfunction

   function automatic logic [VW-1:0] all_lanes(input int v);
      logic [VW-1:0] r;
      for (int k = 0; k < int'(LANES); k++) r[k*DATA_W +: DATA_W] = DATA_W'(v);
      return r;
   endfunction

   function automatic logic [VW-1:0] ramp();
      logic [VW-1:0] r;
      for (int k = 0; k < int'(LANES); k++) r[k*DATA_W +: DATA_W] = DATA_W'(k);
      return r;
   endfunction

   function automatic logic [VW-1:0] lane0(input int v);
      logic [VW-1:0] r;
      r = '0;
      r[DATA_W-1:0] = DATA_W'(v);
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vec();
      logic [VW-1:0] r;
      for (int k = 0; k < int'(LANES); k++) r[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      return r;
   endfunction

   // Reference model and scoreboard, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         model_acc = 0;
         exp_q.delete();
      end else begin
         if (bus_s.out_valid && bus_s.out_ready) begin
            obs_q.push_back(bus_s.out_data);
            if (exp_q.size() == 0) begin
               check("sb_unexpected_result", 64'(bus_s.out_data), 64'hDEAD);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_data_sat",  64'(bus_s.out_data), 64'(e.d_s));
               check("sb_flag_sat",  64'(bus_s.out_sat),  64'(e.f_s));
               check("sb_data_wrap", 64'(bus_w.out_data), 64'(e.d_w));
               check("sb_flag_wrap", 64'(bus_w.out_sat),  64'(e.f_w));
            end
         end
         if (bus_s.in_valid && bus_s.in_ready) begin
            model_acc = model_acc + dot(bus_s.in_a, bus_s.in_b);
            if (bus_s.in_last) begin
               exp_q.push_back(conv(model_acc));
               model_acc = 0;
            end
         end
      end
   end

   // Present one beat (called at posedge+1); returns posedge+1 after acceptance.
   task automatic drive(input logic last, input logic [VW-1:0] a, input logic [VW-1:0] b);
      int n;
      bus_s.in_valid = 1'b1;
      bus_s.in_last  = last;
      bus_s.in_a     = a;
      bus_s.in_b     = b;
      n = 0;
      forever begin
         @(negedge clk);
         if (bus_s.in_ready) break;
         n++;
         if (n > 50) begin
            check("drive_timeout", 64'd1, 64'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      bus_s.in_valid = 1'b0;
      bus_s.in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      bus_s.in_valid = 1'b0;
      bus_s.in_last  = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Count negedges until out_valid; leaves the caller at that negedge.
   task automatic wait_result(output int cycles);
      cycles = 0;
      forever begin
         @(negedge clk);
         cycles++;
         if (bus_s.out_valid) break;
         if (cycles > 40) begin
            check("result_timeout", 64'd1, 64'd0);
            break;
         end
      end
   endtask

   task automatic realign();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lat;
      int len;
      n_checks        = 0;
      n_errors        = 0;
      model_acc       = 0;
      rand_done       = 1'b0;
      rst             = 1'b1;
      bus_s.in_valid  = 1'b0;
      bus_s.in_last   = 1'b0;
      bus_s.in_a      = '0;
      bus_s.in_b      = '0;
      bus_s.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_in_ready",  64'(bus_s.in_ready),  64'd1);
      check("rst_out_valid", 64'(bus_s.out_valid), 64'd0);
      check("rst_out_data",  64'(bus_s.out_data),  64'd0);
      check("rst_out_sat",   64'(bus_s.out_sat),   64'd0);
      check("rst_busy",      64'(busy_s),          64'd0);
      realign();

      // Single beat, all lanes 2*3 -> 60 three cycles after acceptance.
      drive(1'b1, all_lanes(2), all_lanes(3));
      wait_result(lat);
      check("t1_latency", 64'(lat), 64'd3);
      check("t1_data",    64'(bus_s.out_data), 64'd60);
      check("t1_sat",     64'(bus_s.out_sat),  64'd0);
      realign();
      idle(2);

      // Three beats of sum(k)=45 -> 135, nothing emitted early.
      drive(1'b0, all_lanes(1), ramp());
      check("t2_no_early_1", 64'(bus_s.out_valid), 64'd0);
      drive(1'b0, all_lanes(1), ramp());
      check("t2_no_early_2", 64'(bus_s.out_valid), 64'd0);
      drive(1'b1, all_lanes(1), ramp());
      wait_result(lat);
      check("t2_latency", 64'(lat), 64'd3);
      check("t2_data",    64'(bus_s.out_data), 64'd135);
      realign();
      idle(2);

      // 10 * 2^30 overflows 32 bits: clamp vs wrap.
      drive(1'b1, all_lanes(-32768), all_lanes(-32768));
      wait_result(lat);
      check("t3_sat_data",  64'(bus_s.out_data), 64'h7FFF_FFFF);
      check("t3_sat_flag",  64'(bus_s.out_sat),  64'd1);
      check("t3_wrap_data", 64'(bus_w.out_data), 64'h8000_0000);
      check("t3_wrap_flag", 64'(bus_w.out_sat),  64'd1);
      realign();
      idle(2);

      // Backpressure: four single-beat vectors, consumer stalled 6 cycles.
      obs_q.delete();
      fork
         begin
            for (int k = 1; k <= 4; k++) drive(1'b1, lane0(k), lane0(1));
            idle(0);
         end
         begin
            bus_s.out_ready = 1'b0;
            repeat (6) begin
               @(negedge clk);
               if (bus_s.out_valid) begin
                  check("t4_hold_data",  64'(bus_s.out_data), 64'd1);
                  check("t4_hold_ready", 64'(bus_s.in_ready), 64'd0);
               end
            end
            @(posedge clk);
            #1;
            bus_s.out_ready = 1'b1;
         end
      join
      idle(10);
      check("t4_count", 64'(obs_q.size()), 64'd4);
      for (int k = 0; k < 4; k++) begin
         if (k < obs_q.size()) check("t4_order", 64'(obs_q[k]), 64'(k + 1));
      end

      // Bubbles between beats: 10 + 10 -> 20; partial sum keeps busy high.
      drive(1'b0, all_lanes(1), all_lanes(1));
      idle(3);
      check("t5_busy_mid", 64'(busy_s), 64'd1);
      drive(1'b1, all_lanes(1), all_lanes(1));
      wait_result(lat);
      check("t5_data", 64'(bus_s.out_data), 64'd20);
      realign();
      idle(3);
      check("t5_busy_idle", 64'(busy_s), 64'd0);

      // Reset mid-vector discards the partial sum.
      drive(1'b0, all_lanes(1), all_lanes(1));
      drive(1'b0, all_lanes(1), all_lanes(1));
      rst = 1'b1;
      realign();
      rst = 1'b0;
      @(negedge clk);
      check("t6_out_valid", 64'(bus_s.out_valid), 64'd0);
      check("t6_out_data",  64'(bus_s.out_data),  64'd0);
      check("t6_out_sat",   64'(bus_s.out_sat),   64'd0);
      check("t6_busy",      64'(busy_s),          64'd0);
      check("t6_in_ready",  64'(bus_s.in_ready),  64'd1);
      realign();
      drive(1'b1, all_lanes(1), all_lanes(1));
      wait_result(lat);
      check("t6_data", 64'(bus_s.out_data), 64'd10);
      realign();
      idle(3);

      // Random vectors with random bubbles and consumer stalls.
      fork
         begin
            while (!rand_done) begin
               @(posedge clk);
               #1;
               bus_s.out_ready = ($urandom_range(3) != 0);
            end
            bus_s.out_ready = 1'b1;
         end
         begin
            for (int v = 0; v < 1000; v++) begin
               len = int'($urandom_range(3, 1));
               for (int b = 0; b < len; b++) begin
                  if ($urandom_range(3) == 0) idle(int'($urandom_range(2, 1)));
                  if ($urandom_range(7) == 0)
                     drive(b == len - 1, all_lanes(-32768), all_lanes(($urandom_range(1) == 0) ? -32768 : 32767));
                  else
                     drive(b == len - 1, rand_vec(), rand_vec());
               end
            end
            rand_done = 1'b1;
         end
      join
      idle(20);
      check("sb_leftover", 64'(exp_q.size()), 64'd0);
      check("end_busy",    64'(busy_s),       64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
